// File: rtl/mmio_pkg.sv
// Shared types and default constants for the MMIO bus controller.
// The gpio_in synchroniser is enabled by defining MMIO_GPIO_IN_SYNC_EN.
package mmio_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RAM_ACC  = 3'd1,
    RAM_WAIT = 3'd2,
    GPIO_ACC = 3'd3,
    ERR      = 3'd4,
    DONE     = 3'd5
  } mmio_state_e;

  typedef enum logic [1:0] {
    REGION_NONE = 2'd0,
    REGION_RAM  = 2'd1,
    REGION_GPIO = 2'd2
  } mmio_region_e;

  localparam logic [31:0] RAM_BASE_DEFAULT  = 32'h1001_0000;
  localparam logic [31:0] GPIO_BASE_DEFAULT = 32'h1001_0400;

  // Index width that stays legal when only one item exists.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational address decode: region select, misalignment flag,
// RAM word index and GPIO channel index for a byte address.
module mmio_addr_decode
  import mmio_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    RAM_DEPTH_LOG2 = 8,
  parameter int                    NUM_GPIO       = 4,
  parameter int                    CH_W           = 2,
  parameter logic [ADDR_WIDTH-1:0] RAM_BASE       = ADDR_WIDTH'(RAM_BASE_DEFAULT),
  parameter logic [ADDR_WIDTH-1:0] GPIO_BASE      = ADDR_WIDTH'(GPIO_BASE_DEFAULT)
) (
  input  logic [ADDR_WIDTH-1:0]     addr,
  output mmio_region_e              region,
  output logic                      misaligned,
  output logic [RAM_DEPTH_LOG2-1:0] ram_idx,
  output logic [CH_W-1:0]           gpio_ch
);

  localparam logic [ADDR_WIDTH:0] RAM_SPAN  = (ADDR_WIDTH+1)'(4) << RAM_DEPTH_LOG2;
  localparam logic [ADDR_WIDTH:0] GPIO_SPAN = (ADDR_WIDTH+1)'(4 * NUM_GPIO);

  // One extra bit so an address below a base wraps to a huge offset
  // and fails the span compare instead of aliasing into the region.
  logic [ADDR_WIDTH:0] ram_off;
  logic [ADDR_WIDTH:0] gpio_off;

  assign ram_off  = {1'b0, addr} - {1'b0, RAM_BASE};
  assign gpio_off = {1'b0, addr} - {1'b0, GPIO_BASE};

  always_comb begin
    region = REGION_NONE;
    if (ram_off < RAM_SPAN) begin
      region = REGION_RAM;
    end else if (gpio_off < GPIO_SPAN) begin
      region = REGION_GPIO;
    end
  end

  assign misaligned = (addr[1:0] != 2'b00);
  assign ram_idx    = ram_off[RAM_DEPTH_LOG2+1:2];
  assign gpio_ch    = gpio_off[CH_W+1:2];

endmodule

// File: rtl/mmio_bus_ctrl.sv
// Single-outstanding MMIO controller routing word accesses to a sync RAM or
// GPIO channels. Define MMIO_GPIO_IN_SYNC_EN to add a 2-flop gpio_in synchroniser.
module mmio_bus_ctrl
  import mmio_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    RAM_DEPTH_LOG2 = 8,
  parameter int                    NUM_GPIO       = 4,
  parameter int                    GPIO_WIDTH     = 8,
  parameter logic [ADDR_WIDTH-1:0] RAM_BASE       = ADDR_WIDTH'(RAM_BASE_DEFAULT),
  parameter logic [ADDR_WIDTH-1:0] GPIO_BASE      = ADDR_WIDTH'(GPIO_BASE_DEFAULT)
) (
  input  logic                           clk,
  input  logic                           reset,
  // Handshake: req is sampled only in IDLE; the access is accepted on that
  // edge, and completes with a single-cycle ready pulse (err qualifies it).
  input  logic                           req,
  input  logic                           we,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  output logic                           ready,
  output logic                           err,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           ram_en,
  output logic                           ram_we,
  output logic [RAM_DEPTH_LOG2-1:0]      ram_addr,
  output logic [DATA_WIDTH-1:0]          ram_wdata,
  input  logic [DATA_WIDTH-1:0]          ram_rdata,
  output logic [NUM_GPIO*GPIO_WIDTH-1:0] gpio_out,
  input  logic [NUM_GPIO*GPIO_WIDTH-1:0] gpio_in,
  output mmio_state_e                    dbg_state
);

  localparam int CH_W = idx_width(NUM_GPIO);
  localparam int GW   = NUM_GPIO * GPIO_WIDTH;

  mmio_state_e               state_q;
  mmio_state_e               state_d;
  mmio_region_e              dec_region;
  logic                      dec_misaligned;
  logic [RAM_DEPTH_LOG2-1:0] dec_ram_idx;
  logic [CH_W-1:0]           dec_gpio_ch;

  logic                      we_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [RAM_DEPTH_LOG2-1:0] ram_idx_q;
  logic [CH_W-1:0]           gpio_ch_q;
  logic                      err_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic [GW-1:0]             gpio_out_q;
  logic [GW-1:0]             gpio_src;
  logic [GPIO_WIDTH-1:0]     gpio_rd;
  logic                      accept;

  mmio_addr_decode #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .RAM_DEPTH_LOG2 (RAM_DEPTH_LOG2),
    .NUM_GPIO       (NUM_GPIO),
    .CH_W           (CH_W),
    .RAM_BASE       (RAM_BASE),
    .GPIO_BASE      (GPIO_BASE)
  ) u_decode (
    .addr       (addr),
    .region     (dec_region),
    .misaligned (dec_misaligned),
    .ram_idx    (dec_ram_idx),
    .gpio_ch    (dec_gpio_ch)
  );

`ifdef MMIO_GPIO_IN_SYNC_EN
  logic [GW-1:0] gpio_sync1_q;
  logic [GW-1:0] gpio_sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_sync1_q <= '0;
      gpio_sync2_q <= '0;
    end else begin
      gpio_sync1_q <= gpio_in;
      gpio_sync2_q <= gpio_sync1_q;
    end
  end

  assign gpio_src = gpio_sync2_q;
`else
  assign gpio_src = gpio_in;
`endif

  assign accept  = (state_q == IDLE) && req;
  assign gpio_rd = gpio_src[int'(gpio_ch_q)*GPIO_WIDTH +: GPIO_WIDTH];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; misalignment takes priority over region decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (dec_misaligned) begin
            state_d = ERR;
          end else begin
            case (dec_region)
              REGION_RAM:  state_d = RAM_ACC;
              REGION_GPIO: state_d = GPIO_ACC;
              default:     state_d = ERR;
            endcase
          end
        end
      end
      RAM_ACC:  state_d = RAM_WAIT;
      RAM_WAIT: state_d = DONE;
      GPIO_ACC: state_d = DONE;
      ERR:      state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    ready     = 1'b0;
    err       = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = ram_idx_q;
    ram_wdata = wdata_q;
    case (state_q)
      RAM_ACC: begin
        ram_en = 1'b1;
        ram_we = we_q;
      end
      DONE: begin
        ready = 1'b1;
        err   = err_q;
      end
      default: ;
    endcase
  end

  // Request capture and data path; the live bus is only looked at on accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q       <= 1'b0;
      wdata_q    <= '0;
      ram_idx_q  <= '0;
      gpio_ch_q  <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      gpio_out_q <= '0;
    end else begin
      if (accept) begin
        we_q      <= we;
        wdata_q   <= wdata;
        ram_idx_q <= dec_ram_idx;
        gpio_ch_q <= dec_gpio_ch;
        err_q     <= dec_misaligned || (dec_region == REGION_NONE);
      end
      case (state_q)
        RAM_WAIT: begin
          if (!we_q) begin
            rdata_q <= ram_rdata;
          end
        end
        GPIO_ACC: begin
          if (we_q) begin
            gpio_out_q[int'(gpio_ch_q)*GPIO_WIDTH +: GPIO_WIDTH] <= wdata_q[GPIO_WIDTH-1:0];
          end else begin
            rdata_q <= DATA_WIDTH'(gpio_rd);
          end
        end
        ERR: rdata_q <= '0;
        default: ;
      endcase
    end
  end

  assign rdata     = rdata_q;
  assign gpio_out  = gpio_out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Bench for mmio_bus_ctrl: directed spec scenarios plus randomized accesses
// checked against an address-map reference model with its own RAM image.
module tb_mmio_bus_ctrl;
  import mmio_pkg::*;

  localparam logic [31:0] RAM_B  = 32'h1001_0000;
  localparam logic [31:0] GPIO_B = 32'h1001_0400;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic        ready, err;
  logic [31:0] rdata;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [31:0] gpio_out;
  logic [31:0] gpio_in = '0;
  mmio_state_e dbg_state;

  mmio_bus_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .err(err), .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .gpio_out(gpio_out), .gpio_in(gpio_in), .dbg_state(dbg_state)
  );

  // Power-up image of the RAM, shared by the RAM environment and the model
  function automatic logic [31:0] init_word(input int i);
    return 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0011);
  endfunction

  // Synchronous RAM environment, one-cycle read latency, read-before-write
  logic [31:0] env_mem [256];
  bit          env_written [256];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= env_written[ram_addr] ? env_mem[ram_addr] : init_word(int'(ram_addr));
      if (ram_we) begin
        env_mem[ram_addr]     <= ram_wdata;
        env_written[ram_addr] <= 1'b1;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [int];
  logic [31:0] ref_gpio = '0;
  logic [31:0] last_rdata = '0;
  int checks = 0;
  int errors = 0;

  // 0 = error, 1 = RAM, 2 = GPIO; idx = word index or channel
  function automatic int classify(input logic [31:0] a, output int idx);
    idx = 0;
    if (a[1:0] != 2'b00) return 0;
    if (a >= RAM_B && a < RAM_B + 32'd1024) begin
      idx = int'((a - RAM_B) / 4);
      return 1;
    end
    if (a >= GPIO_B && a < GPIO_B + 32'd16) begin
      idx = int'((a - GPIO_B) / 4);
      return 2;
    end
    return 0;
  endfunction

  function automatic logic [31:0] ref_read(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
  endfunction

  // ---------------- driver ----------------
  int          obs_lat, obs_en_cnt, obs_en_k;
  logic        obs_ram_we, obs_err, obs_ready_after;
  logic [7:0]  obs_ram_addr;
  logic [31:0] obs_ram_wdata, obs_rdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one access, scramble the bus after acceptance, observe until ready.
  task automatic run_access(input logic w, input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = w; addr = a; wdata = d;
    tick();
    req = 1'b0; we = 1'($urandom_range(0, 1)); addr = $urandom; wdata = $urandom;
    obs_lat = 0; obs_en_cnt = 0; obs_en_k = 0; obs_ram_we = 1'b0; obs_ram_addr = '0;
    obs_ram_wdata = '0; obs_rdata = '0; obs_err = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (ram_en) begin
        obs_en_cnt++;
        if (obs_en_k == 0) begin
          obs_en_k = k; obs_ram_we = ram_we; obs_ram_addr = ram_addr; obs_ram_wdata = ram_wdata;
        end
      end
      if (ready) begin
        obs_lat = k; obs_rdata = rdata; obs_err = err;
        break;
      end
      tick();
    end
    tick();
    obs_ready_after = ready;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
    checks++; if (ram_en !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram got en=%b we=%b want 0", ram_en, ram_we); end
    checks++; if (gpio_out !== 32'h0) begin errors++; $display("FAIL reset_gpio got %h want 0", gpio_out); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d want IDLE", dbg_state); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_ram_directed();
    run_access(1'b1, 32'h1001_0008, 32'hDEAD_BEEF);
    ref_mem[2] = 32'hDEAD_BEEF;
    checks++; if (obs_en_k !== 1 || obs_en_cnt !== 1) begin errors++; $display("FAIL ram_wr_en got k=%0d cnt=%0d want k=1 cnt=1", obs_en_k, obs_en_cnt); end
    checks++; if (obs_ram_we !== 1'b1 || obs_ram_addr !== 8'd2) begin errors++; $display("FAIL ram_wr_port got we=%b addr=%0d want we=1 addr=2", obs_ram_we, obs_ram_addr); end
    checks++; if (obs_ram_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_wr_data got %h want deadbeef", obs_ram_wdata); end
    checks++; if (obs_lat !== 3 || obs_err !== 1'b0) begin errors++; $display("FAIL ram_wr_done got lat=%0d err=%b want lat=3 err=0", obs_lat, obs_err); end
    checks++; if (obs_ready_after !== 1'b0) begin errors++; $display("FAIL ram_wr_pulse got ready=%b after done want 0", obs_ready_after); end
    run_access(1'b0, 32'h1001_0008, 32'h0);
    last_rdata = 32'hDEAD_BEEF;
    checks++; if (obs_rdata !== 32'hDEAD_BEEF || obs_err !== 1'b0) begin errors++; $display("FAIL ram_rd got rdata=%h err=%b want deadbeef err=0", obs_rdata, obs_err); end
    checks++; if (obs_lat !== 3 || obs_ram_we !== 1'b0) begin errors++; $display("FAIL ram_rd_lat got lat=%0d we=%b want lat=3 we=0", obs_lat, obs_ram_we); end
  endtask

  task automatic test_gpio_directed();
    run_access(1'b1, 32'h1001_0404, 32'h0000_00A5);
    ref_gpio[15:8] = 8'hA5;
    checks++; if (gpio_out !== 32'h0000_A500) begin errors++; $display("FAIL gpio_wr got %h want 0000a500", gpio_out); end
    checks++; if (obs_lat !== 2 || obs_err !== 1'b0 || obs_en_cnt !== 0) begin errors++; $display("FAIL gpio_wr_done got lat=%0d err=%b en=%0d want 2/0/0", obs_lat, obs_err, obs_en_cnt); end
    gpio_in = $urandom;
    gpio_in[15:8] = 8'h3C;
    repeat (3) tick();
    run_access(1'b0, 32'h1001_0404, 32'hFFFF_FFFF);
    last_rdata = 32'h0000_003C;
    checks++; if (obs_rdata !== 32'h0000_003C || obs_lat !== 2) begin errors++; $display("FAIL gpio_rd got rdata=%h lat=%0d want 0000003c lat=2", obs_rdata, obs_lat); end
  endtask

  task automatic test_err();
    logic [31:0] bad [5];
    bad = '{32'h1001_0402, 32'h2000_0000, 32'h1001_0410, 32'h1000_FFFC, 32'h1001_0001};
    foreach (bad[i]) begin
      run_access(1'b1, bad[i], 32'hFFFF_FFFF);
      last_rdata = 32'h0;
      checks++; if (obs_err !== 1'b1 || obs_lat !== 2) begin errors++; $display("FAIL err_done addr=%h got err=%b lat=%0d want err=1 lat=2", bad[i], obs_err, obs_lat); end
      checks++; if (obs_en_cnt !== 0 || obs_rdata !== 32'h0) begin errors++; $display("FAIL err_side addr=%h got en=%0d rdata=%h want 0/0", bad[i], obs_en_cnt, obs_rdata); end
      checks++; if (gpio_out !== ref_gpio) begin errors++; $display("FAIL err_gpio addr=%h got %h want %h", bad[i], gpio_out, ref_gpio); end
    end
  endtask

  task automatic test_random();
    logic [31:0] edges [7];
    logic [31:0] a, d, exp_rd;
    logic w;
    int cls, idx, exp_lat;
    edges = '{RAM_B - 32'd4, GPIO_B + 32'd16, GPIO_B + 32'd12, RAM_B + 32'd1020, 32'h0, 32'hFFFF_FFFC, RAM_B};
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0:       a = RAM_B + 32'($urandom_range(0, 255)) * 4;
        1:       a = GPIO_B + 32'($urandom_range(0, 3)) * 4;
        2:       a = RAM_B + 32'($urandom_range(0, 1100));
        default: a = edges[$urandom_range(0, 6)];
      endcase
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      gpio_in = $urandom;
      repeat (3) tick();
      cls = classify(a, idx);
      exp_lat = (cls == 1) ? 3 : 2;
      exp_rd = last_rdata;
      if (cls == 0) exp_rd = 32'h0;
      else if (cls == 1 && !w) exp_rd = ref_read(idx);
      else if (cls == 2 && !w) exp_rd = {24'h0, gpio_in[idx*8 +: 8]};
      run_access(w, a, d);
      if (cls == 1 && w) ref_mem[idx] = d;
      if (cls == 2 && w) ref_gpio[idx*8 +: 8] = d[7:0];
      last_rdata = exp_rd;
      checks++; if (obs_lat !== exp_lat || obs_err !== (cls == 0)) begin errors++; $display("FAIL rnd_done a=%h got lat=%0d err=%b want lat=%0d err=%b", a, obs_lat, obs_err, exp_lat, cls == 0); end
      checks++; if (obs_rdata !== exp_rd) begin errors++; $display("FAIL rnd_rdata a=%h we=%b got %h want %h", a, w, obs_rdata, exp_rd); end
      checks++; if (obs_en_cnt !== ((cls == 1) ? 1 : 0)) begin errors++; $display("FAIL rnd_en a=%h got %0d want %0d", a, obs_en_cnt, (cls == 1) ? 1 : 0); end
      if (cls == 1) begin
        checks++; if (obs_ram_addr !== 8'(idx) || obs_ram_we !== w) begin errors++; $display("FAIL rnd_ram a=%h got addr=%0d we=%b want addr=%0d we=%b", a, obs_ram_addr, obs_ram_we, idx, w); end
        if (w) begin
          checks++; if (obs_ram_wdata !== d) begin errors++; $display("FAIL rnd_ram_wdata got %h want %h", obs_ram_wdata, d); end
        end
      end
      checks++; if (gpio_out !== ref_gpio) begin errors++; $display("FAIL rnd_gpio a=%h got %h want %h", a, gpio_out, ref_gpio); end
      checks++; if (obs_ready_after !== 1'b0) begin errors++; $display("FAIL rnd_pulse a=%h ready stayed high", a); end
    end
  endtask

  task automatic test_reset_mid();
    int ready_seen;
    run_access(1'b1, GPIO_B + 32'd4, 32'h0000_0077);
    ref_gpio[15:8] = 8'h77;
    req = 1'b1; we = 1'b0; addr = RAM_B + 32'd28; wdata = '0;
    tick();
    req = 1'b0;
    tick();
    #2 reset = 1'b0;
    #1;
    checks++; if (ready !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL midrst_out got ready=%b err=%b rdata=%h want 0", ready, err, rdata); end
    checks++; if (ram_en !== 1'b0 || ram_we !== 1'b0 || gpio_out !== 32'h0) begin errors++; $display("FAIL midrst_side got en=%b we=%b gpio=%h want 0", ram_en, ram_we, gpio_out); end
    ready_seen = 0;
    repeat (3) begin
      tick();
      if (ready) ready_seen++;
    end
    checks++; if (ready_seen !== 0) begin errors++; $display("FAIL midrst_pulse got %0d ready pulses want 0", ready_seen); end
    reset = 1'b1;
    ref_gpio = '0;
    tick();
    run_access(1'b0, RAM_B + 32'd28, 32'h0);
    last_rdata = ref_read(7);
    checks++; if (obs_rdata !== ref_read(7) || obs_lat !== 3 || obs_err !== 1'b0) begin errors++; $display("FAIL midrst_next got rdata=%h lat=%0d err=%b want %h lat=3 err=0", obs_rdata, obs_lat, obs_err, ref_read(7)); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] got_mask, exp_mask;
    int rd_bad;
    gpio_in = $urandom;
    repeat (3) tick();
    req = 1'b1; we = 1'b0; addr = GPIO_B + 32'd8; wdata = $urandom;
    got_mask = '0; rd_bad = 0;
    // Accept, GPIO access, DONE, then one IDLE cycle before the next accept
    for (int k = 0; k < 12; k++) exp_mask[k] = (k % 3 == 1);
    for (int k = 0; k < 12; k++) begin
      tick();
      got_mask[k] = ready;
      if (ready && rdata !== {24'h0, gpio_in[23:16]}) rd_bad++;
      if (k == 11) req = 1'b0;
    end
    tick();
    last_rdata = {24'h0, gpio_in[23:16]};
    checks++; if (got_mask !== exp_mask) begin errors++; $display("FAIL b2b_ready got %b want %b", got_mask, exp_mask); end
    checks++; if (rd_bad !== 0) begin errors++; $display("FAIL b2b_rdata got %0d wrong reads want 0", rd_bad); end
    checks++; if (gpio_out !== ref_gpio) begin errors++; $display("FAIL b2b_gpio got %h want %h", gpio_out, ref_gpio); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ram_directed();
    test_gpio_directed();
    test_err();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_bus_ctrl.md
MMIO_BUS_CTRL -- requirements
Module: mmio_bus_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: byte address width.
REQ-003 SHALL have parameter RAM_DEPTH_LOG2, default 8: log2 of RAM word count.
REQ-004 SHALL have parameter NUM_GPIO, default 4: GPIO channel count, 1..16.
REQ-005 SHALL have parameter GPIO_WIDTH, default 8: bits per GPIO channel.
REQ-006 SHALL have parameters RAM_BASE, default 32'h1001_0000, and GPIO_BASE, default 32'h1001_0400: region base addresses.
REQ-007 SHALL have port clk  input  1: single clock, rising edge.
REQ-008 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-009 SHALL have ports req / we  input  1 / 1: access request; 1 = write.
REQ-010 SHALL have ports addr / wdata  input  ADDR_WIDTH / DATA_WIDTH: byte address; write data.
REQ-011 SHALL have ports ready / err  output  1 / 1: one-cycle completion pulse; error qualifier.
REQ-012 SHALL have port rdata  output  DATA_WIDTH: read data, valid while ready=1.
REQ-013 SHALL have ports ram_en / ram_we  output  1 / 1, ram_addr  output  RAM_DEPTH_LOG2, ram_wdata  output  DATA_WIDTH, ram_rdata  input  DATA_WIDTH (synchronous RAM, 1-cycle read latency).
REQ-014 SHALL have ports gpio_out  output  NUM_GPIO*GPIO_WIDTH and gpio_in  input  NUM_GPIO*GPIO_WIDTH; channel k occupies bits [k*GPIO_WIDTH +: GPIO_WIDTH].

Function
REQ-015 SHALL implement FSM states IDLE, RAM_ACC, RAM_WAIT, GPIO_ACC, ERR, DONE.
REQ-016 In IDLE with req=1 SHALL latch addr, we, wdata and decode: misaligned (addr[1:0]!=0) -> ERR; RAM region [RAM_BASE, RAM_BASE+4*2^RAM_DEPTH_LOG2) -> RAM_ACC; GPIO region [GPIO_BASE, GPIO_BASE+4*NUM_GPIO) -> GPIO_ACC; else -> ERR.
REQ-017 RAM_ACC SHALL assert ram_en for exactly one cycle with ram_we=latched we, ram_addr=(addr-RAM_BASE)>>2, ram_wdata=latched wdata; next state RAM_WAIT.
REQ-018 RAM_WAIT SHALL capture ram_rdata into rdata (reads) and go to DONE; RAM access ready latency = 3 cycles after accept edge.
REQ-019 GPIO_ACC, channel k=(addr-GPIO_BASE)>>2: write SHALL update gpio_out channel k with wdata[GPIO_WIDTH-1:0], other channels unchanged; read SHALL return channel k input zero-extended; next state DONE.
REQ-020 ERR SHALL perform no RAM or GPIO write, set rdata=0, go to DONE with err=1.
REQ-021 DONE SHALL assert ready=1 for exactly one cycle (err=1 only for ERR path), then return to IDLE; req is not sampled in DONE.
REQ-022 req SHALL be ignored in every state except IDLE; addr/wdata changes during a transaction SHALL not affect it.
REQ-023 Outside DONE, ready=0, err=0; rdata holds last value.

Reset
REQ-024 reset=0 SHALL asynchronously force state IDLE, ready=0, err=0, rdata=0, ram_en=0, ram_we=0, gpio_out=0, sync flops=0, including mid-transaction (aborted access has no further effect).

Configuration
REQ-025 With MMIO_GPIO_IN_SYNC_EN defined, gpio_in SHALL pass through a 2-flop synchroniser per bit before read (2-cycle input latency); without it, gpio_in SHALL be sampled directly in GPIO_ACC.

Structure
REQ-026 Shared package mmio_pkg SHALL hold the FSM state enum and default base-address constants.
REQ-027 Address decode SHALL be a sub-module mmio_addr_decode (combinational: region select, misalign flag, RAM word index, GPIO channel index).

Verification
REQ-028 Write 32'hDEADBEEF to 32'h1001_0008 -> ram_en=1, ram_we=1, ram_addr=2 one cycle after accept; ready 3 cycles after accept, err=0.
REQ-029 Read 32'h1001_0008 with RAM returning 32'hDEADBEEF -> rdata=32'hDEADBEEF with ready, err=0.
REQ-030 Write 32'h0000_00A5 to 32'h1001_0404 -> gpio_out[15:8]=8'hA5, others 0, ready 2 cycles after accept; read with gpio_in[15:8]=8'h3C -> rdata=32'h0000_003C.
REQ-031 Write to 32'h1001_0402 and to 32'h2000_0000 -> ready with err=1, ram_en never asserted, gpio_out unchanged.
REQ-032 reset=0 asserted during RAM_WAIT -> all outputs zero immediately, no ready pulse; next request completes normally.
REQ-033 req held high through DONE -> exactly one ready per IDLE acceptance, second access starts from IDLE.
